// File: rtl/clock4_set_ctrl_if.sv
// Purpose: groups the button pulses, live time and edit/load outputs that pass
//          between the button front-end, the time-set controller and top_clock4.
// Signals:
//   i_mode/i_inc/i_dec  single-cycle button pulses
//   i_hour/i_min/i_sec  live time from the counter
//   o_en, o_load        counter enable and one-cycle load strobe
//   o_hour/o_min/o_sec  edited time (load value)
//   o_field             edit field highlight (0 run, 1 hour, 2 min, 3 sec)
// Modports: master drives the pulses and live time; slave is the controller.
interface clock4_set_ctrl_if #(
    parameter int unsigned P_SEC_BIT  = 6,
    parameter int unsigned P_MIN_BIT  = 6,
    parameter int unsigned P_HOUR_BIT = 5
);
    logic                  i_mode;
    logic                  i_inc;
    logic                  i_dec;
    logic [P_SEC_BIT-1:0]  i_sec;
    logic [P_MIN_BIT-1:0]  i_min;
    logic [P_HOUR_BIT-1:0] i_hour;
    logic                  o_en;
    logic                  o_load;
    logic [P_SEC_BIT-1:0]  o_sec;
    logic [P_MIN_BIT-1:0]  o_min;
    logic [P_HOUR_BIT-1:0] o_hour;
    logic [1:0]            o_field;

    modport master (
        output i_mode, i_inc, i_dec, i_sec, i_min, i_hour,
        input  o_en, o_load, o_sec, o_min, o_hour, o_field
    );

    modport slave (
        input  i_mode, i_inc, i_dec, i_sec, i_min, i_hour,
        output o_en, o_load, o_sec, o_min, o_hour, o_field
    );
endinterface

// File: rtl/clock4_set_ctrl.sv
// Purpose: time-setting controller for top_clock4. A mode pulse freezes the
//          counter and captures live time; mode then steps hour -> min -> sec
//          -> commit, inc/dec edit the selected field with wrap-around, and
//          the commit issues a one-cycle load strobe. An idle edit aborts
//          after P_TIMEOUT cycles without loading.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    slave side of clock4_set_ctrl_if (pulses/live time in, en/load/edit out)
module clock4_set_ctrl #(
    parameter int unsigned P_SEC_BIT  = 6,
    parameter int unsigned P_MIN_BIT  = 6,
    parameter int unsigned P_HOUR_BIT = 5,
    parameter int unsigned P_TIMEOUT  = 1000
) (
    input  logic               clk,
    input  logic               reset,
    clock4_set_ctrl_if.slave   bus
);

    localparam int unsigned TO_W     = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MS_MAX   = 59;

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_SET_HOUR = 3'd1,
        S_SET_MIN  = 3'd2,
        S_SET_SEC  = 3'd3,
        S_LOAD     = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  en_q, en_d;
    logic                  load_q, load_d;
    logic [1:0]            field_q, field_d;
    logic [P_HOUR_BIT-1:0] hour_q, hour_d;
    logic [P_MIN_BIT-1:0]  min_q, min_d;
    logic [P_SEC_BIT-1:0]  sec_q, sec_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;

    logic pulse;
    logic adjust;

    // Wrapping +/-1; out-of-range captured values restart from 0 first.
    function automatic logic [31:0] step(input logic [31:0] v,
                                         input logic [31:0] max,
                                         input logic        up);
        logic [31:0] base;
        base = (v > max) ? 32'd0 : v;
        if (up) step = (base == max) ? 32'd0 : base + 32'd1;
        else    step = (base == 32'd0) ? max : base - 32'd1;
    endfunction

    assign pulse  = bus.i_mode | bus.i_inc | bus.i_dec;
    assign adjust = bus.i_inc ^ bus.i_dec;

    // Next-state, edit-register and timeout logic.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        load_d  = 1'b0;
        field_d = 2'd0;

        case (state_q)
            S_RUN: begin
                if (bus.i_mode) begin
                    state_d = S_SET_HOUR;
                    hour_d  = bus.i_hour;
                    min_d   = bus.i_min;
                    sec_d   = bus.i_sec;
                    cnt_d   = '0;
                end
            end
            S_SET_HOUR, S_SET_MIN, S_SET_SEC: begin
                if (bus.i_mode) begin
                    cnt_d = '0;
                    case (state_q)
                        S_SET_HOUR: state_d = S_SET_MIN;
                        S_SET_MIN:  state_d = S_SET_SEC;
                        default:    state_d = S_LOAD;
                    endcase
                end else if (pulse) begin
                    cnt_d = '0;
                    if (adjust) begin
                        case (state_q)
                            S_SET_HOUR: hour_d = P_HOUR_BIT'(step(32'(hour_q), HOUR_MAX, bus.i_inc));
                            S_SET_MIN:  min_d  = P_MIN_BIT'(step(32'(min_q), MS_MAX, bus.i_inc));
                            default:    sec_d  = P_SEC_BIT'(step(32'(sec_q), MS_MAX, bus.i_inc));
                        endcase
                    end
                end else if (cnt_q == TO_W'(P_TIMEOUT - 1)) begin
                    // Idle too long: abandon the edit without loading.
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_LOAD: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Outputs are registered from the upcoming state so they align with it.
        en_d   = (state_d == S_RUN);
        load_d = (state_d == S_LOAD);
        case (state_d)
            S_SET_HOUR:         field_d = 2'd1;
            S_SET_MIN:          field_d = 2'd2;
            S_SET_SEC, S_LOAD:  field_d = 2'd3;
            default:            field_d = 2'd0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            en_q    <= 1'b0;
            load_q  <= 1'b0;
            field_q <= 2'd0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            load_q  <= load_d;
            field_q <= field_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_en    = en_q;
    assign bus.o_load  = load_q;
    assign bus.o_field = field_q;
    assign bus.o_hour  = hour_q;
    assign bus.o_min   = min_q;
    assign bus.o_sec   = sec_q;

endmodule
